// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: rotates one-cold row drive, classifies each full scan frame,
// debounces across frames and reports one key event per press. `KEY_FIFO_EN adds an event FIFO.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DIV        = 250000,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic       ghost,
    output logic       overflow
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB      = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} class_t;
    typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_HELD, S_RELEASE_WAIT} state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [2:0][3:0]  snap_q;
    logic             tick, frame_done;

    logic [3:0][3:0]  frm_rows;
    logic [4:0]       n_low;
    logic [3:0]       frm_code;
    class_t           frm_cls;

    class_t           prev_cls_q;
    logic [3:0]       prev_code_q;
    logic [3:0]       stable_q, stable_d;
    logic             same_frame, reached, is_cand;
    logic             ghost_q;

    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic             held_q, held_d;
    logic             emit;

    // ---------------- scan timing ----------------
    always_comb begin
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
        row_d      = tick ? row_q + 2'd1 : row_q;
        frame_done = tick && (row_q == 2'd3);
        keypadRow  = ~(4'b1000 >> row_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            row_q  <= '0;
            snap_q <= '1;
        end else begin
            div_q <= div_d;
            row_q <= row_d;
            if (tick) begin
                case (row_q)
                    2'd0:    snap_q[0] <= keypadCol;
                    2'd1:    snap_q[1] <= keypadCol;
                    2'd2:    snap_q[2] <= keypadCol;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- frame classification ----------------
    // Row 3 is taken straight from the pins on the frame-complete tick instead of a snapshot slot.
    always_comb begin
        frm_rows = {keypadCol, snap_q[2], snap_q[1], snap_q[0]};
        n_low    = '0;
        frm_code = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (!frm_rows[2'(r)][2'(3 - c)]) begin
                    n_low    = n_low + 5'd1;
                    frm_code = {2'(r), 2'(c)};
                end
            end
        end
        if (n_low == 5'd0) begin
            frm_cls = CLS_NONE;
        end else if (n_low == 5'd1) begin
            frm_cls = CLS_ONE;
        end else begin
            frm_cls = CLS_MULTI;
        end
    end

    always_comb begin
        same_frame = (frm_cls == prev_cls_q) &&
                     ((frm_cls != CLS_ONE) || (frm_code == prev_code_q));
        if (!same_frame) begin
            stable_d = 4'd1;
        end else if (stable_q >= DEB) begin
            stable_d = DEB;
        end else begin
            stable_d = stable_q + 4'd1;
        end
        reached = (stable_d >= DEB);
        is_cand = (frm_cls == CLS_ONE) && (frm_code == cand_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_cls_q  <= CLS_NONE;
            prev_code_q <= '0;
            stable_q    <= '0;
            ghost_q     <= 1'b0;
        end else if (frame_done) begin
            prev_cls_q  <= frm_cls;
            prev_code_q <= frm_code;
            stable_q    <= stable_d;
            ghost_q     <= (frm_cls == CLS_MULTI);
        end
    end

    // ---------------- debounce FSM ----------------
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        held_d  = held_q;
        emit    = 1'b0;
        if (frame_done) begin
            case (state_q)
                S_IDLE: begin
                    // Accepting straight from IDLE only matters when DEBOUNCE_FRAMES is 1.
                    if (frm_cls == CLS_ONE) begin
                        cand_d = frm_code;
                        if (reached) begin
                            state_d = S_HELD;
                            held_d  = 1'b1;
                            emit    = 1'b1;
                        end else begin
                            state_d = S_PRESS_WAIT;
                        end
                    end
                end
                S_PRESS_WAIT: begin
                    if (!is_cand) begin
                        state_d = S_IDLE;
                    end else if (reached) begin
                        state_d = S_HELD;
                        held_d  = 1'b1;
                        emit    = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!is_cand) begin
                        state_d = S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (is_cand) begin
                        state_d = S_HELD;
                    end else if ((frm_cls == CLS_NONE) && reached) begin
                        state_d = S_IDLE;
                        held_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            held_q  <= held_d;
        end
    end

    assign key_held = held_q;
    assign ghost    = ghost_q;

    // ---------------- event output ----------------
`ifdef KEY_FIFO_EN
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             full, pop, do_write;

    always_comb begin
        full     = (cnt_q == FULL_CNT);
        pop      = (cnt_q != '0) && key_ready;
        do_write = emit && (!full || pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[wr_q] <= cand_d;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (emit && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign key_valid = (cnt_q != '0);
    assign key_code  = mem_q[rd_q];
    assign overflow  = ovf_q;
`else
    logic       valid_q;
    logic [3:0] code_q;
    logic       unused_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= emit;
            if (emit) begin
                code_q <= cand_d;
            end
        end
    end

    assign unused_ready = key_ready;
    assign key_valid    = valid_q;
    assign key_code     = code_q;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce (SCAN_DIV=4, DEBOUNCE_FRAMES=3): frame-level keypad model,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_keypad_scan_debounce;

    localparam int DEB    = 3;
    localparam int FDEPTH = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  keypadCol;
    logic [3:0]  keypadRow;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_held;
    logic        ghost;
    logic        overflow;
    logic [15:0] keys;

    int n_chk = 0;
    int n_err = 0;

    keypad_scan_debounce #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (DEB),
        .FIFO_DEPTH      (FDEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .keypadCol (keypadCol),
        .keypadRow (keypadRow),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .ghost     (ghost),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    function automatic logic [3:0] drive_cols(input logic [3:0] row, input logic [15:0] k);
        logic [3:0] col;
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (row[2'(3 - r)] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (k[4'(r * 4 + c)]) col[2'(3 - c)] = 1'b0;
                end
            end
        end
        return col;
    endfunction

    assign keypadCol = drive_cols(keypadRow, keys);

    function automatic int first_key(input logic [15:0] k);
        for (int i = 0; i < 16; i++) begin
            if (k[4'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc;
    int         hist[$];
    bit         m_held, m_valid, m_ghost, m_ovf;
    logic [3:0] m_code;
    logic [3:0] fq[$];

    always @(posedge clock or negedge reset) begin
        bit         ev;
        bit         same;
        int         sig;
        int         nk;
        logic [3:0] ecode;
`ifdef KEY_FIFO_EN
        bit         pop;
`endif
        ev    = 0;
        ecode = '0;
        if (!reset) begin
            cyc = 0;
            hist.delete();
            fq.delete();
            m_held  = 0;
            m_valid = 0;
            m_ghost = 0;
            m_ovf   = 0;
            m_code  = '0;
        end else begin
            cyc++;
`ifdef KEY_FIFO_EN
            pop = (fq.size() > 0) && key_ready;
`endif
            if (cyc % 16 == 0) begin
                nk      = $countones(keys);
                sig     = (nk == 0) ? -1 : ((nk == 1) ? first_key(keys) : 16);
                m_ghost = (nk > 1);
                hist.push_back(sig);
                if (hist.size() > DEB) void'(hist.pop_front());
                same = (hist.size() == DEB);
                foreach (hist[i]) if (hist[i] != sig) same = 0;
                if (same && !m_held && sig >= 0 && sig < 16) begin
                    ev     = 1;
                    ecode  = 4'(sig);
                    m_held = 1;
                end else if (same && m_held && sig == -1) begin
                    m_held = 0;
                end
            end
`ifdef KEY_FIFO_EN
            if (pop) void'(fq.pop_front());
            if (ev) begin
                if (fq.size() < FDEPTH) fq.push_back(ecode);
                else m_ovf = 1;
            end
            m_valid = (fq.size() > 0);
            if (m_valid) m_code = fq[0];
`else
            m_valid = ev;
            if (ev) m_code = ecode;
`endif
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        logic [3:0] er;
        er = 4'b1000 >> ((cyc / 4) % 4);
        er = ~er;
        chk("row", keypadRow, er);
        chk("valid", key_valid, m_valid);
        chk("held", key_held, m_held);
        chk("ghost", ghost, m_ghost);
        chk("overflow", overflow, m_ovf);
`ifdef KEY_FIFO_EN
        if (m_valid) chk("code", key_code, m_code);
`else
        chk("code", key_code, m_code);
`endif
    end

    // Accepted events as seen by a consumer.
    logic [3:0] ev_code[$];
    int         ev_cyc[$];

    always @(negedge clock) begin
`ifdef KEY_FIFO_EN
        if (reset && key_valid && key_ready) begin
`else
        if (reset && key_valid) begin
`endif
            ev_code.push_back(key_code);
            ev_cyc.push_back(cyc);
        end
    end

    task automatic frames(input logic [15:0] m, input int n);
        keys = m;
        repeat (16 * n) @(negedge clock);
    endtask

    task automatic chk_event(input string nm, input int idx, input int code, input int cy);
        if (ev_code.size() <= idx) begin
            chk({nm, "_present"}, ev_code.size(), idx + 1);
        end else begin
            chk({nm, "_code"}, ev_code[idx], code);
            chk({nm, "_cycle"}, ev_cyc[idx], cy);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [3:0] row_tbl [4];
        int         fcodes [5];
        logic [15:0] m;
        int         n0;
        row_tbl = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        fcodes  = '{1, 4, 9, 10, 15};
        reset     = 1'b0;
        keys      = '0;
        key_ready = 1'b1;

        repeat (3) @(negedge clock);
        chk("rst_row", keypadRow, 4'b0111);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_held", key_held, 0);
        chk("rst_ghost", ghost, 0);
        chk("rst_ovf", overflow, 0);
        #1 reset = 1'b1;

        // Idle frame 0: row drive sequence, 4 clocks per row.
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (i % 4 == 0) chk("row_seq", keypadRow, row_tbl[i / 4]);
        end
        frames(16'h0000, 1);
        chk("idle_no_event", ev_code.size(), 0);

        // Row 1 / col 2 held 5 frames, accepted at end of third frame.
        frames(16'h0040, 5);
        chk_event("k6", 0, 6, 80);
        chk("k6_held", key_held, 1);
        frames(16'h0000, 2);
        chk("k6_held_rel2", key_held, 1);
        frames(16'h0000, 1);
        chk("k6_released", key_held, 0);

        // Bounce on key 0.
        frames(16'h0001, 1);
        frames(16'h0000, 1);
        frames(16'h0001, 3);
        frames(16'h0000, 3);
        chk("bounce_count", ev_code.size(), 2);
        chk_event("bounce", 1, 0, 240);

        // Keys 0 and 5 together, then key 5 released.
        frames(16'h0021, 4);
        chk("ghost_set", ghost, 1);
        chk("ghost_no_event", ev_code.size(), 2);
        frames(16'h0001, 3);
        chk("ghost_clear", ghost, 0);
        frames(16'h0000, 3);
        chk_event("deghost", 2, 0, 400);

        // Slide from key 2 to key 8 without release, then a clean key 8 press.
        frames(16'h0004, 3);
        frames(16'h0100, 3);
        chk("slide_held", key_held, 1);
        frames(16'h0000, 3);
        chk("slide_count", ev_code.size(), 4);
        chk_event("slide_k2", 3, 2, 496);
        frames(16'h0100, 3);
        frames(16'h0000, 3);
        chk("k8_count", ev_code.size(), 5);
        chk_event("k8", 4, 8, 640);

`ifdef KEY_FIFO_EN
        // Five presses with the consumer stalled: four buffered, fifth dropped.
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m = '0;
            m[4'(fcodes[i])] = 1'b1;
            frames(m, 3);
            frames(16'h0000, 3);
        end
        chk("fifo_valid", key_valid, 1);
        chk("fifo_head", key_code, 1);
        chk("fifo_overflow", overflow, 1);
        #1 key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", key_valid, 1);
            chk("drain_code", key_code, fcodes[i]);
            @(negedge clock);
        end
        chk("drain_empty", key_valid, 0);
        chk("drain_ovf_sticky", overflow, 1);
`endif

        // Reset in the middle of a frame while a key is down.
        keys = 16'h0040;
        repeat (20) @(negedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_row", keypadRow, 4'b0111);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(negedge clock);
        n0 = ev_code.size();
        #1 reset = 1'b1;
        frames(16'h0040, 3);
        chk("post_rst_held", key_held, 1);
        frames(16'h0000, 3);
        chk_event("post_rst", n0, 6, 48);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage of the tic-tac-toe move logic.
- Drives the 4x4 matrix keypad rows and samples the active-low columns.
- Debounces each full scan frame and emits exactly one clean key event per physical press, as a 4-bit key code.
- Replaces raw row/column sampling in the move logic; the move logic consumes key_valid/key_code and no longer touches keypadRow/keypadCol.

Parameters:
- SCAN_DIV, 250000: clock cycles spent on each row before sampling and advancing.
- DEBOUNCE_FRAMES, 3: consecutive identical frames required to accept a press or a release (1..15).
- FIFO_DEPTH, 4: key buffer depth; used only with KEY_FIFO_EN (power of 2, 2..16).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- keypadCol  in  4  column sense, active-low; bit3 = column 0
- keypadRow  out  4  row drive, one-cold; 4'b0111 = row 0
- key_valid  out  1  key event available
- key_code  out  4  {row[1:0], col[1:0]}; codes 0,1,2,4,5,6,8,9,10 = grid cells 0..8
- key_ready  in  1  consumer accepts event; used only with KEY_FIFO_EN, ignored otherwise
- key_held  out  1  debounced key currently down
- ghost  out  1  last completed frame had more than one key pressed
- overflow  out  1  sticky flag: an event was dropped (KEY_FIFO_EN only, else tied 0)

Behaviour:
- Reset, asynchronous active-low, overrides everything: keypadRow=4'b0111, key_valid=0, key_code=0, key_held=0, ghost=0, overflow=0, div counter=0, row index=0, stable count=0, FSM=IDLE, FIFO empty.
- Divider counts 0..SCAN_DIV-1. tick = (count==SCAN_DIV-1). Count wraps to 0 on tick.
- On tick, columns are captured into the snapshot slot for the current row, then keypadRow rotates 0111->1011->1101->1110->0111.
- A frame completes on the tick that samples row 3 (keypadRow==1110). Frame length = 4*SCAN_DIV clocks.
- Frame classification, evaluated on the frame-complete tick:
  - NONE: no low column bits in any row.
  - ONE(code): exactly one low bit across all 16 positions.
  - MULTI: two or more low bits. Sets ghost=1 and is treated as a distinct class that never matches NONE or ONE.
  - ghost is updated every frame.
- Stability counter:
  - Same class and code as the previous frame: counter increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise: counter = 1.
- FSM, one transition per frame-complete tick:
  - IDLE: ONE -> PRESS_WAIT. NONE or MULTI -> stay.
  - PRESS_WAIT: counter reaches DEBOUNCE_FRAMES with ONE(code) -> HELD; emit event with code; key_held=1. Class or code changes -> IDLE.
  - HELD: any non-ONE(code) frame -> RELEASE_WAIT. This includes a different key or MULTI; no event is emitted for it.
  - RELEASE_WAIT: NONE stable for DEBOUNCE_FRAMES -> IDLE, key_held=0. Original ONE(code) reappears -> HELD, no new event.
- Event emission without KEY_FIFO_EN:
  - key_valid is high for exactly one clock, the clock after the accepting tick.
  - key_code is registered at the same time and holds its value until the next event.
- Latency: press stable from frame N onward -> key_valid asserted 1 clock after completion of frame N+DEBOUNCE_FRAMES-1.
- Bouncing: any mismatch frame during PRESS_WAIT restarts debounce from IDLE. No event is lost for a press that subsequently holds steady.
- Reset mid-frame: scan restarts at row 0 and the partial snapshot is discarded.

Optional Feature:
- Macro: KEY_FIFO_EN.
- Defined:
  - Events are pushed into a FIFO_DEPTH-entry FIFO.
  - key_valid = FIFO not empty; key_code = FIFO head.
  - Pop on the clock where key_valid && key_ready.
  - Simultaneous push and pop when full: both occur and the count is unchanged.
  - Push when full with no pop: the new event is dropped and overflow is set; only reset clears overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Undefined: single-cycle pulse behaviour above; key_ready ignored; overflow tied 0.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame=16 clocks):
- Reset then idle: keypadRow sequence 0111,1011,1101,1110 each held 4 clocks; key_valid never asserts; all outputs 0 during reset.
- Hold row 1 / col 2 (keypadCol=1101 while keypadRow=1011) for 5 frames: one key_valid pulse, key_code=4'd6, key_held=1 from that clock. Release for 3 frames -> key_held=0.
- Bounce: key 0 pressed 1 frame, released 1 frame, then pressed 3 frames -> exactly one pulse, code 0, after the third stable frame.
- Keys 0 and 5 held together 4 frames -> ghost=1, no event. Release key 5 -> key 0 accepted after 3 frames.
- Hold key 2, slide to key 8 without release -> only code 2 reported. Release 3 frames, press 8 -> code 8 reported.
- KEY_FIFO_EN, key_ready=0: 5 distinct presses -> key_valid=1 with head=first code, overflow=1. Then key_ready=1 -> 4 codes drain in press order and key_valid falls.
